// File: rtl/keypad_entry.sv
// keypad_entry: scans a 4x4 active-low matrix keypad one row at a time,
// debounces press and release, decodes the key and builds a 0..255 decimal
// entry. '#' commits the entry, '*' clears it, A-D are reported but inert.
//
// Handshake: key_valid and commit are single-cycle strobes with no back-pressure.
// key_code is valid whenever key_valid is high. commit is raised exactly one
// cycle after the key_valid that carried '#'. committed is valid from that cycle on.
module keypad_entry #(
    parameter int CLK_HZ         = 50_000_000,
    parameter int SCAN_HZ        = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] row,
    input  logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic [7:0] value,
    output logic [1:0] digits,
    output logic [7:0] committed,
    output logic       commit
);

    localparam int TICK_DIV = CLK_HZ / (SCAN_HZ * 4);
    localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CNT_W    = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q;
    logic             tick;
    logic [3:0]       col_meta, col_sync;
    logic [3:0]       col_low;
    logic             any_low;
    logic [1:0]       first_col;
    logic [1:0]       row_idx_q, row_idx_d;
    logic [1:0]       key_col_q, key_col_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_key;
    logic [11:0]      acc_tmp;
    logic [7:0]       acc_sat;

    // Map a (row, column) position to its key code.
    function automatic logic [3:0] decode_key(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'b00_00: code = 4'd1;
            4'b00_01: code = 4'd2;
            4'b00_10: code = 4'd3;
            4'b00_11: code = 4'd10;
            4'b01_00: code = 4'd4;
            4'b01_01: code = 4'd5;
            4'b01_10: code = 4'd6;
            4'b01_11: code = 4'd11;
            4'b10_00: code = 4'd7;
            4'b10_01: code = 4'd8;
            4'b10_10: code = 4'd9;
            4'b10_11: code = 4'd12;
            4'b11_00: code = 4'd14;
            4'b11_01: code = 4'd0;
            4'b11_10: code = 4'd15;
            default:  code = 4'd13;
        endcase
        return code;
    endfunction

    assign tick    = (div_q == DIV_LAST);
    assign col_low = ~col_sync;
    assign any_low = |col_low;
    assign row     = ~(4'b0001 << row_idx_q);

    // Scan-rate divider: one tick per row step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    // Two-flop synchroniser for the asynchronous column inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_meta <= 4'hF;
            col_sync <= 4'hF;
        end else begin
            col_meta <= col;
            col_sync <= col_meta;
        end
    end

    // Lowest low column wins when several are pressed together.
    always_comb begin
        casez (col_low)
            4'b???1: first_col = 2'd0;
            4'b??10: first_col = 2'd1;
            4'b?100: first_col = 2'd2;
            default: first_col = 2'd3;
        endcase
    end

    // Scan/debounce FSM state and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SCAN;
            row_idx_q <= 2'd0;
            key_col_q <= 2'd0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            row_idx_q <= row_idx_d;
            key_col_q <= key_col_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state logic. Everything advances only on the scan tick.
    always_comb begin
        state_d   = state_q;
        row_idx_d = row_idx_q;
        key_col_d = key_col_q;
        cnt_d     = cnt_q;
        load_key  = 1'b0;
        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (any_low) begin
                        key_col_d = first_col;
                        cnt_d     = CNT_W'(1);
                        state_d   = DEBOUNCE;
                    end else begin
                        row_idx_d = row_idx_q + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (col_low[key_col_q]) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_d == CNT_DONE) begin
                            load_key = 1'b1;
                            cnt_d    = '0;
                            state_d  = HELD;
                        end
                    end else begin
                        cnt_d     = '0;
                        row_idx_d = row_idx_q + 2'd1;
                        state_d   = SCAN;
                    end
                end
                HELD: begin
                    if (any_low) begin
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_d == CNT_DONE) begin
                            cnt_d     = '0;
                            row_idx_d = row_idx_q + 2'd1;
                            state_d   = SCAN;
                        end
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = SCAN;
                end
            endcase
        end
    end

    // Register the decoded key and raise key_valid for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_code  <= 4'd0;
            key_valid <= 1'b0;
        end else begin
            key_valid <= load_key;
            if (load_key) begin
                key_code <= decode_key(row_idx_q, key_col_q);
            end
        end
    end

    assign acc_tmp = ({4'd0, value} * 12'd10) + {8'd0, key_code};
    assign acc_sat = (acc_tmp > 12'd255) ? 8'hFF : acc_tmp[7:0];

    // Entry buffer: accumulate digits, clear on '*', commit on '#'.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value     <= 8'd0;
            digits    <= 2'd0;
            committed <= 8'd0;
            commit    <= 1'b0;
        end else begin
            commit <= 1'b0;
            if (key_valid) begin
                if (key_code <= 4'd9) begin
                    if (digits != 2'd3) begin
                        value  <= acc_sat;
                        digits <= digits + 2'd1;
                    end
                end else if (key_code == 4'd14) begin
                    value  <= 8'd0;
                    digits <= 2'd0;
                end else if (key_code == 4'd15) begin
                    committed <= value;
                    commit    <= 1'b1;
                    value     <= 8'd0;
                    digits    <= 2'd0;
                end
            end
        end
    end

endmodule
